wave_out: RTL and testbench

WAVE_OUT -- requirements
Module: wave_out

---
 rtl/wave_out_pkg.sv | 43 ++++
 rtl/wave_sine_lut.sv | 18 +
 rtl/wave_out.sv | 50 +++++
 tb/tb_wave_out.sv | 129 ++++++++++++
 4 files changed

// File: rtl/wave_out_pkg.sv
// Shared constants, waveform encodings and the sine-sample generator for wave_out.
// The sine table is built at elaboration from integer-only fixed-point arithmetic.
package wave_out_pkg;

  localparam int unsigned ACC_W = 16;
  localparam int unsigned OUT_W = 8;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SAW    = 2'b11
  } wave_sel_e;

  // pi scaled by 2^30
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(127.5 + 127.5*sin(2*pi*p/256)) using a Q30 Taylor series on the folded quarter wave
  function automatic logic [7:0] sine_sample(input int unsigned p);
    int unsigned q;
    logic        neg;
    longint      x;
    longint      x2;
    longint      term;
    longint      s;
    longint      v;
    neg = (p >= 128);
    q   = p % 128;
    if (q > 64) q = 128 - q;
    x    = (longint'(q) * PI_Q30) >>> 7;
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int unsigned k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    if (neg) s = -s;
    v = ((longint'(256) <<< 30) + longint'(255) * s) >>> 31;
    return v[7:0];
  endfunction

endpackage

// File: rtl/wave_sine_lut.sv
// Combinational 256-entry sine lookup: 8-bit phase to unsigned 8-bit sample.
module wave_sine_lut
  import wave_out_pkg::*;
(
  input  logic [7:0] i_phase,
  output logic [7:0] o_sample
);

  logic [7:0] w_tab [256];

  for (genvar g = 0; g < 256; g++) begin : g_tab
    localparam logic [7:0] SAMPLE = sine_sample(g);
    assign w_tab[g] = SAMPLE;
  end

  assign o_sample = w_tab[i_phase];

endmodule

// File: rtl/wave_out.sv
// DDS waveform generator: phase accumulator, waveform select mux and registered output.
module wave_out
  import wave_out_pkg::*;
#(
  parameter int unsigned ACC_W = wave_out_pkg::ACC_W,
  parameter int unsigned OUT_W = wave_out_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       wave_selector,
  input  logic [11:0]      freq_ctl,
  output logic [OUT_W-1:0] output_wave
);

  logic [ACC_W-1:0] r_acc;
  logic [7:0]       w_phase;
  logic [7:0]       w_sine;
  logic [7:0]       w_tri;
  logic [7:0]       w_sample;

  assign w_phase = r_acc[ACC_W-1 -: 8];
  assign w_tri   = w_phase[7] ? ~{w_phase[6:0], 1'b0} : {w_phase[6:0], 1'b0};

  wave_sine_lut u_sine (
    .i_phase  (w_phase),
    .o_sample (w_sine)
  );

  always_comb begin
    w_sample = '0;
    case (wave_sel_e'(wave_selector))
      WAVE_SINE:   w_sample = w_sine;
      WAVE_SQUARE: w_sample = w_phase[7] ? '0 : '1;
      WAVE_TRI:    w_sample = w_tri;
      WAVE_SAW:    w_sample = w_phase;
      default:     w_sample = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      output_wave <= '0;
    end else begin
      r_acc       <= r_acc + ACC_W'(freq_ctl);
      output_wave <= OUT_W'(w_sample);
    end
  end

endmodule

// File: tb/tb_wave_out.sv
// Scoreboard bench for wave_out: stimulus pushes reference samples, a monitor pops and compares.
module tb_wave_out;

  localparam real PI = 3.141592653589793;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wave_selector;
  logic [11:0] freq_ctl;
  logic [7:0]  output_wave;

  typedef struct {
    int    exp;
    int    idx;
    string tag;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_acc  = 0;
  int n_step = 0;

  wave_out #(.ACC_W(16), .OUT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wave_selector (wave_selector),
    .freq_ctl      (freq_ctl),
    .output_wave   (output_wave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ref_f(input int sel, input int p);
    case (sel)
      0:       return $rtoi(127.5 + 127.5 * $sin(2.0 * PI * p / 256.0) + 0.5);
      1:       return (p < 128) ? 255 : 0;
      2:       return (p < 128) ? 2 * p : 511 - 2 * p;
      default: return p;
    endcase
  endfunction

  task automatic step(input logic [1:0] sel, input logic [11:0] fc, input string tag);
    sb_item_t it;
    @(negedge clk);
    rst_n         = 1'b1;
    wave_selector = sel;
    freq_ctl      = fc;
    it.exp = ref_f(int'(sel), m_acc / 256);
    it.idx = n_step;
    it.tag = tag;
    sb.push_back(it);
    n_step++;
    m_acc = (m_acc + int'(fc)) % 65536;
  endtask

  task automatic check_now(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: output_wave=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reset asserted between edges; output must clear before the next rising edge.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_now("reset_async", int'(output_wave), 0);
    m_acc  = 0;
    n_step = 0;
    repeat (2) @(posedge clk);
    #1 check_now("reset_hold", int'(output_wave), 0);
  endtask

  initial begin : monitor
    sb_item_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (int'(output_wave) != e.exp) begin
          errors++;
          $display("FAIL %s[%0d]: output_wave=%0d expected=%0d", e.tag, e.idx, output_wave, e.exp);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n         = 1'b0;
    wave_selector = 2'b00;
    freq_ctl      = '0;
    #23 check_now("reset_initial", int'(output_wave), 0);

    for (int i = 0; i < 16390; i++) step(2'b11, 12'd4, "saw_f4");

    mid_reset();
    for (int i = 0; i < 600; i++) step(2'b01, 12'd256, "square_f256");
    mid_reset();
    for (int i = 0; i < 600; i++) step(2'b10, 12'd256, "tri_f256");
    mid_reset();
    for (int i = 0; i < 300; i++) step(2'b00, 12'd256, "sine_f256");

    for (int i = 0; i < 40; i++) step(2'($urandom_range(0, 3)), 12'd4095, "wrap_f4095");
    begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      for (int i = 0; i < 100; i++) step(s, 12'd0, "freeze_f0");
    end

    for (int i = 0; i < 2000; i++)
      step(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)), "random");

    mid_reset();
    for (int i = 0; i < 300; i++) step(2'($urandom_range(0, 3)), 12'd300, "sel_switch");

    @(posedge clk);
    #2 check_now("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
